wf_joystick_board_slave: RTL and testbench

WF_JOYSTICK_BOARD_SLAVE -- requirements
Module: wf_joystick_board_slave

---
 rtl/wf_joystick_board_slave_pkg.sv | 27 ++
 rtl/wf_sync_edge.sv | 31 +++
 rtl/wf_joystick_board_slave.sv | 160 ++++++++++++++++
 tb/tb_wf_joystick_board_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wf_joystick_board_slave_pkg.sv
// Shared constants, state encoding and column decode indices for the joystick board slave.
package wf_joystick_board_slave_pkg;

   localparam int FRAME_BITS = 24;
   localparam int CNT_W      = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = 5'd25;

   localparam int COL_SLIDE_RED   = 0;
   localparam int COL_SLIDE_GREEN = 1;
   localparam int COL_CIRC_RED    = 2;
   localparam int COL_CIRC_GREEN  = 3;
   localparam int COL_STAT_RED    = 4;
   localparam int COL_STAT_BLUE   = 5;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      WAIT_HIGH = 2'd2
   } state_t;

   function automatic logic is_one_hot6(input logic [5:0] v);
      return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/wf_sync_edge.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module wf_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= {STAGES{RESET_VAL}};
         r_prev  <= RESET_VAL;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_q    = r_chain[STAGES-1];
   assign o_rise = o_q & ~r_prev;
   assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/wf_joystick_board_slave.sv
// Serial slave for the joystick board: returns switch/header state, commits LED and header frames.
//  state     | meaning
//  WAIT_HIGH | after reset; wait for synchronizers to flush and LOAD to be high
//  IDLE      | between frames; waiting for LOAD to fall
//  SHIFT     | frame in progress; shifting on CLK_OUT edges until LOAD rises
module wf_joystick_board_slave
   import wf_joystick_board_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        LOAD,
   input  logic        CLK_OUT,
   input  logic        MST_OUT_SLV_IN,
   output logic        MST_IN_SLV_OUT,
   input  logic [7:0]  slide_switches,
   input  logic [4:0]  joystick_switches,
   input  logic [7:0]  header_inputs,
   output logic [7:0]  header_outputs,
   output logic [7:0]  slide_leds_red,
   output logic [7:0]  slide_leds_green,
   output logic [11:0] circle_leds_red,
   output logic [11:0] circle_leds_green,
   output logic [3:0]  status_leds_red,
   output logic [3:0]  status_leds_blue,
   output logic        frame_done,
   output logic        frame_err
);

   localparam logic [1:0] FLUSH_INIT = 2'(SYNC_STAGES);

   logic w_load_q, w_load_rise, w_load_fall;
   logic w_clk_q, w_clk_rise, w_clk_fall;
   logic w_mosi_q, w_mosi_rise, w_mosi_fall;
   logic w_unused;

   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_load (
      .clk(clk), .reset(reset), .i_d(LOAD),
      .o_q(w_load_q), .o_rise(w_load_rise), .o_fall(w_load_fall));

   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
      .clk(clk), .reset(reset), .i_d(CLK_OUT),
      .o_q(w_clk_q), .o_rise(w_clk_rise), .o_fall(w_clk_fall));

   wf_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .i_d(MST_OUT_SLV_IN),
      .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

   assign w_unused = &{1'b0, w_clk_q, w_mosi_rise, w_mosi_fall};

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_flush;
   logic [FRAME_BITS-1:0] r_tx, r_rx;
   logic [CNT_W-1:0]      r_count;
   logic [7:0]            r_hdr, r_sl_red, r_sl_grn;
   logic [11:0]           r_ci_red, r_ci_grn;
   logic [3:0]            r_st_red, r_st_blu;
   logic                  r_done, r_err;
   logic                  w_start, w_rx_shift, w_tx_shift, w_commit, w_fail, w_frame_ok;
   logic [7:0]            w_lit;
   logic [5:0]            w_col;

   assign w_lit      = ~r_rx[23:16];
   assign w_col      = r_rx[13:8];
   assign w_frame_ok = (r_count == CNT_FULL) && (r_rx[15:14] == 2'b00) && is_one_hot6(w_col);

   always_ff @(posedge clk) begin
      if (reset) r_state <= WAIT_HIGH;
      else       r_state <= w_state_nxt;
   end

   // LOAD rise takes priority over any CLK_OUT edge seen in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_rx_shift  = 1'b0;
      w_tx_shift  = 1'b0;
      w_commit    = 1'b0;
      w_fail      = 1'b0;
      case (r_state)
         WAIT_HIGH: if (r_flush == 2'd0 && w_load_q) w_state_nxt = IDLE;
         IDLE: begin
            if (w_load_fall) begin
               w_state_nxt = SHIFT;
               w_start     = 1'b1;
            end
         end
         SHIFT: begin
            if (w_load_rise) begin
               w_state_nxt = IDLE;
               w_commit    = w_frame_ok;
               w_fail      = ~w_frame_ok;
            end else if (w_clk_rise) begin
               w_rx_shift = 1'b1;
            end else if (w_clk_fall) begin
               w_tx_shift = 1'b1;
            end
         end
         default: w_state_nxt = WAIT_HIGH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flush  <= FLUSH_INIT;
         r_tx     <= '0;
         r_rx     <= '0;
         r_count  <= '0;
         r_hdr    <= '0;
         r_sl_red <= '0;
         r_sl_grn <= '0;
         r_ci_red <= '0;
         r_ci_grn <= '0;
         r_st_red <= '0;
         r_st_blu <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= w_commit;
         r_err  <= w_fail;
         if (r_flush != 2'd0) r_flush <= r_flush - 2'd1;

         if (w_start) begin
            r_tx    <= {header_inputs, ~slide_switches, 3'b000, ~joystick_switches};
            r_rx    <= '0;
            r_count <= '0;
         end else if (w_tx_shift) begin
            r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
         end

         if (w_rx_shift) begin
            r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi_q};
            if (r_count != CNT_SAT) r_count <= r_count + 5'd1;
         end

         if (w_commit) begin
            r_hdr <= r_rx[7:0];
            if (w_col[COL_SLIDE_RED])   r_sl_red       <= w_lit;
            if (w_col[COL_SLIDE_GREEN]) r_sl_grn       <= w_lit;
            if (w_col[COL_CIRC_RED])    r_ci_red[7:0]  <= w_lit;
            if (w_col[COL_CIRC_GREEN])  r_ci_grn[7:0]  <= w_lit;
            if (w_col[COL_STAT_RED])  {r_st_red, r_ci_red[11:8]} <= w_lit;
            if (w_col[COL_STAT_BLUE]) {r_st_blu, r_ci_grn[11:8]} <= w_lit;
         end
      end
   end

   assign MST_IN_SLV_OUT    = r_tx[FRAME_BITS-1];
   assign header_outputs    = r_hdr;
   assign slide_leds_red    = r_sl_red;
   assign slide_leds_green  = r_sl_grn;
   assign circle_leds_red   = r_ci_red;
   assign circle_leds_green = r_ci_grn;
   assign status_leds_red   = r_st_red;
   assign status_leds_blue  = r_st_blu;
   assign frame_done        = r_done;
   assign frame_err         = r_err;

endmodule

// File: tb/tb_wf_joystick_board_slave.sv
// Bench for wf_joystick_board_slave: a bit-banged master drives frames, a scoreboard checks results.
module tb_wf_joystick_board_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        LOAD = 1'b1;
   logic        CLK_OUT = 1'b0;
   logic        MST_OUT_SLV_IN = 1'b0;
   logic        MST_IN_SLV_OUT;
   logic [7:0]  slide_switches = '0;
   logic [4:0]  joystick_switches = '0;
   logic [7:0]  header_inputs = '0;
   logic [7:0]  header_outputs;
   logic [7:0]  slide_leds_red, slide_leds_green;
   logic [11:0] circle_leds_red, circle_leds_green;
   logic [3:0]  status_leds_red, status_leds_blue;
   logic        frame_done, frame_err;

   wf_joystick_board_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .LOAD(LOAD), .CLK_OUT(CLK_OUT),
      .MST_OUT_SLV_IN(MST_OUT_SLV_IN), .MST_IN_SLV_OUT(MST_IN_SLV_OUT),
      .slide_switches(slide_switches), .joystick_switches(joystick_switches),
      .header_inputs(header_inputs), .header_outputs(header_outputs),
      .slide_leds_red(slide_leds_red), .slide_leds_green(slide_leds_green),
      .circle_leds_red(circle_leds_red), .circle_leds_green(circle_leds_green),
      .status_leds_red(status_leds_red), .status_leds_blue(status_leds_blue),
      .frame_done(frame_done), .frame_err(frame_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rows;
      logic [1:0] pad;
      logic [5:0] col;
      logic [7:0] hdr;
      int         nbits;
      logic       coinc;
      logic [7:0] sw;
      logic [4:0] joy;
      logic [7:0] hin;
      logic       exp_ok;
   } vec_t;

   typedef struct {
      logic        exp_done;
      logic [47:0] leds;
      logic [7:0]  hdr;
      logic [23:0] miso;
      logic        chk_miso;
   } exp_t;

   exp_t       sb_q[$];
   vec_t       vecs[8];
   logic [7:0] m_bank[6];
   logic [7:0] m_hdr;
   int         tests = 0;
   int         fails = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] dut_leds();
      return {slide_leds_red, slide_leds_green, circle_leds_red, circle_leds_green,
              status_leds_red, status_leds_blue};
   endfunction

   function automatic logic [47:0] model_leds();
      logic [7:0] b4, b5;
      b4 = m_bank[4];
      b5 = m_bank[5];
      return {m_bank[0], m_bank[1], b4[3:0], m_bank[2], b5[3:0], m_bank[3], b4[7:4], b5[7:4]};
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 6; k++) m_bank[k] = 8'h00;
      m_hdr = 8'h00;
   endtask

   task automatic shift_bits(input logic [23:0] word, input int first, input int last,
                             inout logic [23:0] miso);
      for (int i = first; i < last; i++) begin
         MST_OUT_SLV_IN = word[23-i];
         repeat (4) @(negedge clk);
         CLK_OUT = 1'b1;
         miso = {miso[22:0], MST_IN_SLV_OUT};
         repeat (4) @(negedge clk);
         CLK_OUT = 1'b0;
      end
   endtask

   // LOAD rise followed by the master's capture pulse, which the slave must ignore
   task automatic end_frame(input logic coinc);
      repeat (4) @(negedge clk);
      LOAD = 1'b1;
      if (coinc) CLK_OUT = 1'b1;
      repeat (4) @(negedge clk);
      if (!coinc) begin
         CLK_OUT = 1'b1;
         repeat (4) @(negedge clk);
      end
      CLK_OUT = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic apply(input vec_t v, input string tag);
      exp_t        e;
      logic [23:0] word, miso;
      int          d0, e0, budget;
      slide_switches    = v.sw;
      joystick_switches = v.joy;
      header_inputs     = v.hin;
      if (v.exp_ok) begin
         for (int k = 0; k < 6; k++) if (v.col[k]) m_bank[k] = ~v.rows;
         m_hdr = v.hdr;
      end
      e.exp_done = v.exp_ok;
      e.leds     = model_leds();
      e.hdr      = m_hdr;
      e.miso     = {v.hin, ~v.sw, 3'b000, ~v.joy};
      e.chk_miso = (v.nbits == 24);
      sb_q.push_back(e);

      d0   = done_cnt;
      e0   = err_cnt;
      word = {v.rows, v.pad, v.col, v.hdr};
      miso = '0;
      LOAD = 1'b0;
      repeat (8) @(negedge clk);
      shift_bits(word, 0, v.nbits, miso);
      end_frame(v.coinc);
      budget = 0;
      while (done_cnt == d0 && err_cnt == e0 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      repeat (6) @(negedge clk);

      e = sb_q.pop_front();
      check({tag, "_done"}, 64'(done_cnt - d0), 64'(e.exp_done ? 1 : 0));
      check({tag, "_err"},  64'(err_cnt - e0),  64'(e.exp_done ? 0 : 1));
      check({tag, "_leds"}, 64'(dut_leds()), 64'(e.leds));
      check({tag, "_hdr"},  64'(header_outputs), 64'(e.hdr));
      if (e.chk_miso) check({tag, "_miso"}, 64'(miso), 64'(e.miso));
   endtask

   initial begin
      vec_t        v;
      logic [23:0] word, miso;
      int          d0, e0;

      //              rows   pad    col    hdr    n   coin  sw     joy       hin    ok
      vecs[0] = '{8'hFE, 2'b00, 6'h01, 8'hA5, 24, 1'b0, 8'h81, 5'b01000, 8'h3C, 1'b1};
      vecs[1] = '{8'h5A, 2'b00, 6'h02, 8'h3C, 24, 1'b0, 8'h00, 5'b00000, 8'hFF, 1'b1};
      vecs[2] = '{8'h00, 2'b00, 6'h04, 8'h11, 23, 1'b0, 8'hFF, 5'b11111, 8'h00, 1'b0};
      vecs[3] = '{8'h0F, 2'b00, 6'h03, 8'h22, 24, 1'b0, 8'h0F, 5'b10101, 8'h96, 1'b0};
      vecs[4] = '{8'h33, 2'b00, 6'h00, 8'h44, 24, 1'b0, 8'hF0, 5'b01010, 8'h69, 1'b0};
      vecs[5] = '{8'h00, 2'b10, 6'h08, 8'h55, 24, 1'b0, 8'h12, 5'b00001, 8'hC3, 1'b0};
      vecs[6] = '{8'hC3, 2'b00, 6'h10, 8'h7E, 24, 1'b1, 8'h34, 5'b10000, 8'h5A, 1'b1};
      vecs[7] = '{8'h99, 2'b00, 6'h20, 8'h81, 24, 1'b0, 8'hAA, 5'b00110, 8'h01, 1'b1};

      clear_model();
      repeat (4) @(negedge clk);
      check("rst_miso", 64'(MST_IN_SLV_OUT), 64'd0);
      check("rst_leds", 64'(dut_leds()), 64'd0);
      check("rst_pulses", 64'({frame_done, frame_err}), 64'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_hdr", 64'(header_outputs), 64'd0);

      for (int i = 0; i < 8; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
         if (i == 0) check("vec0_slide_red", 64'(slide_leds_red), 64'h01);
      end

      // reset in the middle of a frame: the rest of it must vanish silently
      d0   = done_cnt;
      e0   = err_cnt;
      word = 24'h00_01_77;
      miso = '0;
      LOAD = 1'b0;
      repeat (8) @(negedge clk);
      shift_bits(word, 0, 10, miso);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_model();
      shift_bits(word, 10, 24, miso);
      end_frame(1'b0);
      repeat (30) @(negedge clk);
      check("rstmid_done", 64'(done_cnt - d0), 64'd0);
      check("rstmid_err",  64'(err_cnt - e0),  64'd0);
      check("rstmid_leds", 64'(dut_leds()), 64'd0);
      check("rstmid_hdr",  64'(header_outputs), 64'd0);
      v = '{8'hF0, 2'b00, 6'h01, 8'h5A, 24, 1'b0, 8'h00, 5'b00000, 8'hE7, 1'b1};
      apply(v, "postrst");

      for (int c = 0; c < 6; c++) begin
         v = '{8'h00, 2'b00, 6'(1 << c), 8'(c), 24, 1'b0, 8'(c * 17), 5'(c), 8'(~c), 1'b1};
         apply(v, $sformatf("all%0d", c));
      end
      check("all_leds_lit", 64'(dut_leds()), 64'hFFFF_FFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
